stripe_sched: RTL
=================

STRIPE_SCHED -- requirements
Module: stripe_sched

Interface
REQ-001 Parameters SHALL be: DATA_W, 8, byte width; STALL_MAX, 15, stall cycles before timeout flag.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 lane_en  input  4  lane enable mask; bit i enables output lane i.
REQ-005 data_in  input  DATA_W  byte from the upstream serial stream.
REQ-006 valid_in  input  1  data_in valid; upstream SHALL hold data_in while valid_in=1 and in_ready=0.
REQ-007 lane_ready  input  4  per-lane downstream space available.
REQ-008 in_ready  output  1  byte accepted this cycle when valid_in=1.
REQ-009 data_out  output  DATA_W  registered striped byte.
REQ-010 valid_out  output  4  registered one-hot lane strobe, qualifying data_out.
REQ-011 cur_lane  output  2  current round-robin pointer.
REQ-012 timeout_err  output  1  sticky stall-timeout flag.

Function
REQ-013 FSM states SHALL be IDLE, RUN and STALL.
REQ-014 IDLE: cfg_mask <= lane_en every cycle; ptr <= lowest set bit of lane_en; in_ready=0; IDLE->RUN when valid_in=1 and lane_en!=0.
REQ-015 lane_en=0 SHALL keep FSM in IDLE regardless of valid_in.
REQ-016 RUN: in_ready = valid_in & lane_ready[ptr] (combinational); on accept, data_out<=data_in and valid_out<=onehot(ptr) next cycle (latency 1); else valid_out<=0.
REQ-017 On accept, ptr SHALL advance to next set bit of cfg_mask above ptr, wrapping modulo 4; single-bit mask keeps ptr fixed.
REQ-018 RUN->STALL when valid_in=1 and lane_ready[ptr]=0; ptr SHALL NOT change and no other lane SHALL be used.
REQ-019 STALL: stall_cnt increments per cycle; STALL->RUN when lane_ready[ptr]=1 (byte accepted that cycle, stall_cnt cleared).
REQ-020 stall_cnt reaching STALL_MAX SHALL set timeout_err; counter saturates; flag cleared only by reset.
REQ-021 RUN or STALL -> IDLE when valid_in=0; an in-flight valid_out still completes next cycle.
REQ-022 lane_en changes during RUN/STALL SHALL be ignored until IDLE.
REQ-023 cur_lane SHALL equal ptr at all times.

Reset
REQ-024 Asserting reset SHALL asynchronously force: state IDLE, ptr 0, cfg_mask 0, stall_cnt 0, data_out 0, valid_out 0, timeout_err 0; in_ready 0.
REQ-025 Reset mid-stream SHALL drop the pending byte; no valid_out strobe in the cycle after deassertion.

Configuration
REQ-026 Macro STRIPE_SCHED_STATS_EN defined: extra output byte_cnt (16-bit) SHALL count accepted bytes, saturating at 16'hFFFF, cleared by reset only.
REQ-027 Macro undefined: byte_cnt port and counter SHALL NOT exist; all other behaviour identical.

Structure
REQ-028 Shared package stripe_pkg SHALL hold NUM_LANES=4, state enum type and STALL_MAX default.
REQ-029 Combinational sub-module stripe_rr_next (mask, ptr -> next ptr) SHALL compute wrap-around selection.

Verification
REQ-030 lane_en=4'b1111, 8 bytes 0x10..0x17, all ready -> valid_out 0001,0010,0100,1000,0001... with data 0x10..0x17, 1-cycle latency.
REQ-031 lane_en=4'b1010, bytes 0xA0..0xA3 -> lanes 1,3,1,3; cur_lane starts at 1.
REQ-032 lane_ready[2]=0 for 5 cycles at ptr=2 -> in_ready=0 5 cycles, no valid_out, then byte on lane 2; timeout_err stays 0.
REQ-033 lane_ready[0]=0 for 20 cycles, STALL_MAX=15 -> timeout_err=1 from 15th stall cycle, remains 1 after recovery.
REQ-034 valid_in drops after 3 bytes (lanes 0,1,2), restarts -> next byte on lane 0.
REQ-035 reset asserted during STALL -> all outputs 0 immediately; with STRIPE_SCHED_STATS_EN, byte_cnt=0.

Source files
------------

// File: rtl/stripe_pkg.sv
// stripe_pkg: lane count, scheduler state type and default stall limit shared by stripe_sched.
package stripe_pkg;
    localparam int NUM_LANES     = 4;
    localparam int LANE_W        = 2;
    localparam int STALL_MAX_DEF = 15;

    typedef enum logic [1:0] {IDLE, RUN, STALL} state_t;

    function automatic logic [LANE_W-1:0] lowest_bit(input logic [NUM_LANES-1:0] m);
        lowest_bit = '0;
        for (int i = NUM_LANES - 1; i >= 0; i--)
            if (m[i]) lowest_bit = LANE_W'(i);
    endfunction
endpackage

// File: rtl/stripe_rr_next.sv
// stripe_rr_next: next enabled lane strictly above ptr, wrapping; returns ptr when no other lane is set.
module stripe_rr_next
    import stripe_pkg::*;
(
    input  logic [NUM_LANES-1:0] mask_i,
    input  logic [LANE_W-1:0]    ptr_i,
    output logic [LANE_W-1:0]    nxt_o
);
    // Scan downward so the nearest candidate above ptr is written last.
    always_comb begin
        nxt_o = ptr_i;
        for (int i = NUM_LANES - 1; i >= 1; i--)
            if (mask_i[ptr_i + LANE_W'(i)]) nxt_o = ptr_i + LANE_W'(i);
    end
endmodule

// File: rtl/stripe_sched.sv
// stripe_sched: round-robin striping of a byte stream over enabled lanes with stall timeout.
// Define STRIPE_SCHED_STATS_EN to add the saturating byte_cnt output.
module stripe_sched
    import stripe_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int STALL_MAX = STALL_MAX_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_LANES-1:0] lane_en,
    input  logic [DATA_W-1:0]    data_in,
    input  logic                 valid_in,
    input  logic [NUM_LANES-1:0] lane_ready,
    output logic                 in_ready,
    output logic [DATA_W-1:0]    data_out,
    output logic [NUM_LANES-1:0] valid_out,
    output logic [LANE_W-1:0]    cur_lane,
    output logic                 timeout_err
`ifdef STRIPE_SCHED_STATS_EN
    ,
    output logic [15:0]          byte_cnt
`endif
);
    localparam int CNT_W = $clog2(STALL_MAX + 1);

    state_t               state_q, state_d;
    logic [NUM_LANES-1:0] mask_q, mask_d;
    logic [LANE_W-1:0]    ptr_q, ptr_d, ptr_nxt;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [DATA_W-1:0]    data_q, data_d;
    logic [NUM_LANES-1:0] vo_q, vo_d;
    logic                 to_q, to_d;

    stripe_rr_next u_rr (
        .mask_i (mask_q),
        .ptr_i  (ptr_q),
        .nxt_o  (ptr_nxt)
    );

    always_comb begin
        state_d  = state_q;
        mask_d   = mask_q;
        ptr_d    = ptr_q;
        cnt_d    = '0;
        data_d   = data_q;
        vo_d     = '0;
        to_d     = to_q;
        in_ready = 1'b0;
        if (state_q == IDLE) begin
            mask_d  = lane_en;
            ptr_d   = lowest_bit(lane_en);
            state_d = (valid_in && lane_en != '0) ? RUN : IDLE;
        end else if (!valid_in) begin
            state_d = IDLE;
        end else if (lane_ready[ptr_q]) begin
            in_ready = 1'b1;
            data_d   = data_in;
            vo_d     = NUM_LANES'(1) << ptr_q;
            ptr_d    = ptr_nxt;
            state_d  = RUN;
        end else begin
            // Blocked lane holds the pointer; the first blocked cycle already counts.
            state_d = STALL;
            cnt_d   = (cnt_q == CNT_W'(STALL_MAX)) ? cnt_q : cnt_q + 1'b1;
            to_d    = to_q | (cnt_d == CNT_W'(STALL_MAX));
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            mask_q  <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            vo_q    <= '0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            vo_q    <= vo_d;
            to_q    <= to_d;
        end
    end

    assign data_out    = data_q;
    assign valid_out   = vo_q;
    assign cur_lane    = ptr_q;
    assign timeout_err = to_q;

`ifdef STRIPE_SCHED_STATS_EN
    logic [15:0] byte_cnt_q, byte_cnt_d;

    assign byte_cnt_d = (in_ready && byte_cnt_q != 16'hFFFF) ? byte_cnt_q + 16'd1 : byte_cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) byte_cnt_q <= '0;
        else       byte_cnt_q <= byte_cnt_d;
    end

    assign byte_cnt = byte_cnt_q;
`endif
endmodule
